// File: rtl/fifo_pixel_unpacker.sv
// fifo_pixel_unpacker: unpacks LANES-pixel FIFO words into a
// one-pixel-per-beat valid/ready stream grouped by channel count.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fifo_rd_en        read request (credit-limited, never when empty)
//   fifo_rd_data      FIFO word, qualified by fifo_valid
//   fifo_valid        FIFO data-valid, one cycle after an accepted read
//   fifo_empty        FIFO empty flag
//   cfg_ch            channels per pixel position (0 acts as 1)
//   out_data          pixel value
//   out_valid         out_data valid
//   out_ready         downstream accepts the beat
//   out_last          beat is last channel of a pixel position
//   out_ch_idx        channel index of the beat
//   busy              any word queued, in flight, or held at the output
module fifo_pixel_unpacker #(
  parameter  int WORD_WIDTH = 64,
  parameter  int PIX_WIDTH  = 16,
  parameter  int MAX_CH     = 64,
  localparam int LANES      = WORD_WIDTH / PIX_WIDTH,
  localparam int CH_W       = $clog2(MAX_CH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [WORD_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_valid,
  input  logic                  fifo_empty,
  input  logic [CH_W-1:0]       cfg_ch,
  output logic [PIX_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CH_W-1:0]       out_ch_idx,
  output logic                  busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WORD_WIDTH-1:0] q_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  drop;
  logic [LW-1:0]         lane_idx;
  logic [CH_W-1:0]       ch_cnt;
  logic [CH_W-1:0]       ch_lat;

  logic [1:0]            credit;
  logic                  push;
  logic                  head_ok;
  logic [WORD_WIDTH-1:0] head_word;
  logic                  load;
  logic [CH_W-1:0]       cfg_eff;
  logic [CH_W-1:0]       ch_cur;
  logic                  last_n;
  logic                  lane_end;
  logic                  pop;
  logic [PIX_WIDTH-1:0]  lanes [LANES];
  logic [PIX_WIDTH-1:0]  pix;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lanes[i] = head_word[i*PIX_WIDTH +: PIX_WIDTH];
  end

  // The head word stays in the queue until its last lane is used,
  // so occupancy plus the in-flight read is the full credit count.
  // drop masks the first cycle after reset, so no read is issued
  // whose data would be discarded.
  always_comb begin
    credit     = occ + {1'b0, inflight};
    fifo_rd_en = !fifo_empty && (credit < 2'd2) && !rst && !drop;
    push       = fifo_valid && !drop;
    head_ok    = (occ != 2'd0) || push;
    head_word  = (occ != 2'd0) ? q_mem[rd_ptr] : fifo_rd_data;
    load       = head_ok && (!out_valid || out_ready);
    cfg_eff    = (cfg_ch == '0) ? CH_W'(1) : cfg_ch;
    ch_cur     = (ch_cnt == '0) ? cfg_eff : ch_lat;
    last_n     = (ch_cnt == ch_cur - CH_W'(1));
    lane_end   = (lane_idx == LW'(LANES - 1));
    pop        = load && (lane_end || last_n);
    pix        = lanes[lane_idx];
    busy       = (occ != 2'd0) || inflight || out_valid;
  end

  // Bypass: with an empty queue the word is written and consumed
  // on the same edge, so both pointers advance together.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= fifo_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      drop       <= 1'b1;
      lane_idx   <= '0;
      ch_cnt     <= '0;
      ch_lat     <= CH_W'(1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_ch_idx <= '0;
    end else begin
      drop     <= 1'b0;
      inflight <= fifo_rd_en;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= pix;
        out_ch_idx <= ch_cnt;
        out_last   <= last_n;
        if (ch_cnt == '0) ch_lat <= cfg_eff;
        if (last_n) begin
          ch_cnt   <= '0;
          lane_idx <= '0;
        end else begin
          ch_cnt   <= ch_cnt + CH_W'(1);
          lane_idx <= lane_end ? '0 : lane_idx + LW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (occ != 2'd2);
  end

endmodule
